// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package pc_fetch_unit_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INC = 32'd4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StHalt
    } fetch_state_e;

    typedef enum logic [1:0] {
        NpcKeep,
        NpcTarget,
        NpcPending,
        NpcInc
    } npc_sel_e;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC, pending-redirect register and next-PC selection.
module fetch_pc_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    input  npc_sel_e npc_sel,
    input  word_t    target,
    input  logic     pend_set,
    input  logic     pend_clr,
    output word_t    pc,
    output logic     pend_valid,
    output logic     pend_misaligned
);

    word_t pc_q;
    word_t pc_d;
    word_t pend_target_q;
    logic  pend_valid_q;

    always_comb begin
        pc_d = pc_q;
        unique case (npc_sel)
            NpcKeep:    pc_d = pc_q;
            NpcTarget:  pc_d = target;
            NpcPending: pc_d = pend_target_q;
            NpcInc:     pc_d = pc_q + PC_INC;
        endcase
    end

    // A later redirect simply overwrites the pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (pend_set) begin
                pend_valid_q  <= 1'b1;
                pend_target_q <= target;
            end else if (pend_clr) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign pc              = pc_q;
    assign pend_valid      = pend_valid_q;
    assign pend_misaligned = (pend_target_q[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack fetch, valid/ready hand-off to decode.
// Optional FETCH_ALIGN_CHK_EN halts on misaligned redirect targets instead of aligning them.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  branch_taken,
    input  word_t branch_target,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_ack,
    input  word_t imem_rdata,
    output logic  inst_valid,
    output word_t inst_data,
    output word_t inst_pc,
    input  logic  dec_ready,
    output logic  misalign_err
);

`ifdef FETCH_ALIGN_CHK_EN
    localparam bit AlignChk = 1'b1;
    word_t redirect_tgt;
    assign redirect_tgt = branch_target;
`else
    localparam bit AlignChk = 1'b0;
    word_t redirect_tgt;
    assign redirect_tgt = word_align(branch_target);
`endif

    fetch_state_e state_q;
    fetch_state_e state_d;
    npc_sel_e     npc_sel;
    logic         pend_set;
    logic         pend_clr;
    logic         pend_valid;
    logic         pend_misaligned;
    logic         capture;
    logic         tgt_bad;
    logic         pend_bad;
    word_t        pc;
    word_t        inst_data_q;
    word_t        inst_pc_q;

    assign tgt_bad  = AlignChk && (redirect_tgt[1:0] != 2'b00);
    assign pend_bad = AlignChk && pend_misaligned;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .npc_sel         (npc_sel),
        .target          (redirect_tgt),
        .pend_set        (pend_set),
        .pend_clr        (pend_clr),
        .pc              (pc),
        .pend_valid      (pend_valid),
        .pend_misaligned (pend_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        npc_sel  = NpcKeep;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        capture  = 1'b0;
        case (state_q)
            StIdle: begin
                state_d = StReq;
                if (branch_taken) begin
                    npc_sel = NpcTarget;
                    if (tgt_bad) state_d = StHalt;
                end
            end
            StReq: begin
                // The in-flight request is never aborted; redirects wait for the ack.
                if (imem_ack) begin
                    pend_clr = 1'b1;
                    if (branch_taken) begin
                        npc_sel = NpcTarget;
                        if (tgt_bad) state_d = StHalt;
                    end else if (pend_valid) begin
                        npc_sel = NpcPending;
                        if (pend_bad) state_d = StHalt;
                    end else begin
                        capture = 1'b1;
                        state_d = StHold;
                    end
                end else if (branch_taken) begin
                    pend_set = 1'b1;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    npc_sel = NpcTarget;
                    state_d = tgt_bad ? StHalt : StReq;
                end else if (dec_ready) begin
                    npc_sel = NpcInc;
                    state_d = StReq;
                end
            end
            default: state_d = AlignChk ? StHalt : StIdle;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == StReq);
        inst_valid = (state_q == StHold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else if (capture) begin
            inst_data_q <= imem_rdata;
            inst_pc_q   <= pc;
        end
    end

    assign imem_addr = pc;
    assign inst_data = inst_data_q;
    assign inst_pc   = inst_pc_q;

`ifdef FETCH_ALIGN_CHK_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (state_d == StHalt) begin
            misalign_q <= 1'b1;
        end
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle vector table plus fetch scoreboard.
`timescale 1ns/1ps
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam word_t RST_PC = 32'h0000_0100;

    typedef struct {
        logic  bt;
        word_t tgt;
        logic  dr;
        logic  req;
        word_t addr;
        logic  valid;
    } vec_t;

    typedef struct {
        word_t pc;
        word_t data;
    } fetch_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  branch_taken = 1'b0;
    word_t branch_target = '0;
    logic  imem_ack = 1'b0;
    word_t imem_rdata = '0;
    logic  dec_ready = 1'b0;
    logic  imem_req;
    word_t imem_addr;
    logic  inst_valid;
    word_t inst_data;
    word_t inst_pc;
    logic  misalign_err;

    int     n_checks = 0;
    int     n_fail = 0;
    int     mem_lat = 1;
    int     req_age = 0;
    bit     drop_ack = 1'b0;
    fetch_t exp_q[$];
    vec_t   vecs[$];

    pc_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .dec_ready     (dec_ready),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic word_t mem_word(input word_t a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic bt, input word_t tgt, input logic dr,
                           input logic req, input word_t addr, input logic valid);
        vec_t v;
        v.bt = bt; v.tgt = tgt; v.dr = dr; v.req = req; v.addr = addr; v.valid = valid;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive inputs, answer memory, update scoreboard, advance to next negedge.
    task automatic tick(input logic bt, input word_t tgt, input logic dr);
        fetch_t f;
        branch_taken  = bt;
        branch_target = tgt;
        dec_ready     = dr;
        if (imem_req) begin
            if (req_age >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                req_age    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = '0;
                req_age++;
            end
        end else begin
            imem_ack = 1'b0;
            req_age  = 0;
        end
        if (imem_ack && !rst) begin
            if (!bt && !drop_ack) begin
                f.pc   = imem_addr;
                f.data = imem_rdata;
                exp_q.push_back(f);
            end
            drop_ack = 1'b0;
        end else if (bt && imem_req && !rst) begin
            drop_ack = 1'b1;
        end
        if (inst_valid && !rst && (dr || bt)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_inst", inst_pc, 32'hDEAD_DEAD);
            end else begin
                f = exp_q.pop_front();
                if (dr) begin
                    chk("sb_inst_pc", inst_pc, f.pc);
                    chk("sb_inst_data", inst_data, f.data);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, input string name);
        for (int i = 0; i < budget && !inst_valid; i++) tick(1'b0, '0, 1'b0);
        chk(name, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        chk({tag, "_data"}, inst_data, 32'd0);
        chk({tag, "_pc"}, inst_pc, 32'd0);
        chk({tag, "_misalign"}, {31'b0, misalign_err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Sequential fetch from RESET_PC with a 1-cycle memory, then redirect with handshake.
        add_vec(0, '0, 1, 0, 32'h100, 0);
        add_vec(0, '0, 1, 1, 32'h100, 0);
        add_vec(0, '0, 1, 1, 32'h100, 0);
        add_vec(0, '0, 1, 0, 32'h100, 1);
        add_vec(0, '0, 1, 1, 32'h104, 0);
        add_vec(0, '0, 1, 1, 32'h104, 0);
        add_vec(0, '0, 1, 0, 32'h104, 1);
        add_vec(0, '0, 1, 1, 32'h108, 0);
        add_vec(0, '0, 1, 1, 32'h108, 0);
        add_vec(0, '0, 1, 0, 32'h108, 1);
        add_vec(0, '0, 1, 1, 32'h10C, 0);
        add_vec(0, '0, 1, 1, 32'h10C, 0);
        add_vec(1, 32'h300, 1, 0, 32'h10C, 1);
        add_vec(0, '0, 1, 1, 32'h300, 0);
        add_vec(0, '0, 1, 1, 32'h300, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
            tick(vecs[i].bt, vecs[i].tgt, vecs[i].dr);
        end

        // Decode stall: held instruction stays stable, no fetch issued.
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_pc", inst_pc, 32'h300);
            chk("stall_data", inst_data, mem_word(32'h300));
            tick(1'b0, '0, 1'b0);
        end
        tick(1'b0, '0, 1'b1);
        chk("post_stall_req", {31'b0, imem_req}, 32'd1);
        chk("post_stall_addr", imem_addr, 32'h304);

        // Redirect during REQ with a slow memory: address held, data dropped.
        mem_lat = 3;
        tick(1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("pend_hold_req", {31'b0, imem_req}, 32'd1);
            chk("pend_hold_addr", imem_addr, 32'h304);
            chk("pend_hold_valid", {31'b0, inst_valid}, 32'd0);
            tick(1'b0, '0, 1'b0);
        end
        chk("pend_refetch_addr", imem_addr, 32'h200);
        chk("pend_refetch_valid", {31'b0, inst_valid}, 32'd0);
        mem_lat = 1;
        wait_valid(10, "pend_fetch_done");
        tick(1'b0, '0, 1'b1);

        // Redirect in the same cycle as the ack: data dropped, refetch from target.
        chk("ackbr_addr", imem_addr, 32'h204);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, 32'h400, 1'b0);
        chk("ackbr_req", {31'b0, imem_req}, 32'd1);
        chk("ackbr_addr_new", imem_addr, 32'h400);
        chk("ackbr_valid", {31'b0, inst_valid}, 32'd0);
        wait_valid(10, "ackbr_fetch_done");

        // Redirect in HOLD to the top word, then wrap to zero after acceptance.
        tick(1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("hold_br_valid", {31'b0, inst_valid}, 32'd0);
        chk("hold_br_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(10, "wrap_fetch_done");
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick(1'b0, '0, 1'b1);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        wait_valid(10, "zero_fetch_done");

        // Misaligned redirect target.
        tick(1'b1, 32'h202, 1'b0);
`ifdef FETCH_ALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            chk("halt_misalign", {31'b0, misalign_err}, 32'd1);
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_valid", {31'b0, inst_valid}, 32'd0);
            tick(1'b0, '0, 1'b1);
        end
`else
        chk("align_misalign", {31'b0, misalign_err}, 32'd0);
        chk("align_req", {31'b0, imem_req}, 32'd1);
        chk("align_addr", imem_addr, 32'h200);
        wait_valid(10, "align_fetch_done");
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
`endif

        // Mid-operation reset; a memory ack during the reset cycle is ignored.
        rst = 1'b1;
        tick(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk_reset("midrst");
        tick(1'b0, '0, 1'b0);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, RST_PC);
        wait_valid(10, "restart_fetch_done");
        tick(1'b0, '0, 1'b1);
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
